rf_dump_reader: RTL and testbench

//  Read-side companion to the 32x32 pipeline register file: on request, walks a register index

---
 rtl/rf_dump_reader.sv | 143 ++++++++++++++
 tb/tb_rf_dump_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_reader.sv
// Walks a register index range through a spare RF read port and streams
// {index, value} beats over a valid/ready link, with abort and done handshake.
module rf_dump_reader #(
  parameter int NREG   = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] FirstIdx,
  input  logic [ADDR_W-1:0] LastIdx,
  input  logic              Abort,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [ADDR_W-1:0] OutIdx,
  output logic [DATA_W-1:0] OutData,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(NREG - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ADDR_W-1:0]   last_req;
  logic                slot_free;

  // Indices beyond the physical register file are clamped to the top register.
  assign last_req  = (LastIdx > MAX_IDX) ? MAX_IDX : LastIdx;
  assign slot_free = !out_valid_q || OutReady;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          last_d = last_req;
          if (FirstIdx > last_req) begin
            state_d = S_DONE;
          end else begin
            cur_d   = FirstIdx;
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        // A stalled slot leaves cur and the pending beat untouched.
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_idx_d   = cur_q;
          out_data_d  = RdData;
          if (cur_q == last_q) begin
            state_d = S_DRAIN;
          end else begin
            cur_d = cur_q + ADDR_W'(1);
          end
        end
      end

      S_DRAIN: begin
        if (out_valid_q && OutReady) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort beats any other transition, including a final acceptance.
    if (Abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      cur_d       = '0;
      done_d      = 1'b0;
    end

    busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The RF read port is driven only while walking the range.
  assign RdAddr   = (state_q == S_READ) ? cur_q : '0;
  assign OutValid = out_valid_q;
  assign OutIdx   = out_idx_q;
  assign OutData  = out_data_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader with a behavioural 32x32 register file
// (index 0 reads zero, writes land at the clock edge).
module tb_rf_dump_reader;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [4:0]  FirstIdx;
  logic [4:0]  LastIdx;
  logic        Abort;
  logic [4:0]  RdAddr;
  logic [31:0] RdData;
  logic        OutValid;
  logic        OutReady;
  logic [4:0]  OutIdx;
  logic [31:0] OutData;
  logic        Busy;
  logic        Done;

  logic [31:0] rf [32];
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic [4:0]  got_idx  [64];
  logic [31:0] got_data [64];

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (wr_en) rf[wr_addr] <= wr_data;

  assign RdData = (RdAddr == 5'd0) ? 32'd0 : rf[RdAddr];

  rf_dump_reader #(.NREG(32), .ADDR_W(5), .DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .FirstIdx(FirstIdx), .LastIdx(LastIdx),
    .Abort(Abort), .RdAddr(RdAddr), .RdData(RdData), .OutValid(OutValid),
    .OutReady(OutReady), .OutIdx(OutIdx), .OutData(OutData), .Busy(Busy), .Done(Done)
  );

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rf_clear;
    for (int i = 0; i < 32; i++) rf_write(5'(i), 32'd0);
  endtask

  // Runs one dump and records accepted beats; stall uses an OutReady pattern 1,0,0.
  task automatic collect(input logic [4:0] first, input logic [4:0] last, input bit stall,
                         input int max_cyc, output int nb, output int ndone,
                         output int nhold_bad, output bit tmo);
    bit held;
    logic [4:0] h_idx;
    logic [31:0] h_data;
    int after;
    bit rdy;
    nb = 0; ndone = 0; nhold_bad = 0; tmo = 1'b0; held = 1'b0; after = 0;
    Start = 1'b1; FirstIdx = first; LastIdx = last; OutReady = 1'b1;
    step();
    Start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (held && (!OutValid || OutIdx !== h_idx || OutData !== h_data)) nhold_bad++;
      rdy = stall ? (c % 3 == 0) : 1'b1;
      OutReady = rdy;
      held = 1'b0;
      if (OutValid) begin
        if (rdy) begin
          if (nb < 64) begin
            got_idx[nb] = OutIdx;
            got_data[nb] = OutData;
          end
          nb++;
        end else begin
          held = 1'b1; h_idx = OutIdx; h_data = OutData;
        end
      end
      if (Done) ndone++;
      if (ndone > 0) after++;
      if (after > 3) break;
      if (c == max_cyc - 1) tmo = 1'b1;
      step();
    end
    OutReady = 1'b1;
  endtask

  task automatic test_reset;
    vec_cnt++; if (OutValid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %0d want 0", OutValid); end
    vec_cnt++; if (OutIdx !== 5'd0) begin err_cnt++; $display("FAIL reset_idx got %0d want 0", OutIdx); end
    vec_cnt++; if (OutData !== 32'd0) begin err_cnt++; $display("FAIL reset_data got %h want 0", OutData); end
    vec_cnt++; if (Busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %0d want 0", Busy); end
    vec_cnt++; if (Done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %0d want 0", Done); end
    vec_cnt++; if (RdAddr !== 5'd0) begin err_cnt++; $display("FAIL reset_rdaddr got %0d want 0", RdAddr); end
    $display("test_reset: done");
  endtask

  task automatic test_basic;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
    rf_write(5'd1, 32'h11); rf_write(5'd2, 32'h22); rf_write(5'd3, 32'h33);
    Start = 1'b1; FirstIdx = 5'd1; LastIdx = 5'd3; OutReady = 1'b1;
    step();
    Start = 1'b0;
    vec_cnt++; if (OutValid !== 1'b0 || Busy !== 1'b1 || RdAddr !== 5'd1) begin
      err_cnt++; $display("FAIL basic_start got v=%0d b=%0d a=%0d want v=0 b=1 a=1", OutValid, Busy, RdAddr); end
    for (int k = 0; k < 3; k++) begin
      step();
      vec_cnt++; if (OutValid !== 1'b1 || OutIdx !== 5'(k + 1) || OutData !== exp_d[k]) begin
        err_cnt++; $display("FAIL basic_beat%0d got v=%0d idx=%0d data=%h want v=1 idx=%0d data=%h",
                            k, OutValid, OutIdx, OutData, k + 1, exp_d[k]); end
    end
    vec_cnt++; if (Busy !== 1'b1 || RdAddr !== 5'd0) begin
      err_cnt++; $display("FAIL basic_drain got b=%0d a=%0d want b=1 a=0", Busy, RdAddr); end
    step();
    vec_cnt++; if (OutValid !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) begin
      err_cnt++; $display("FAIL basic_after got v=%0d d=%0d b=%0d want 0 0 0", OutValid, Done, Busy); end
    step();
    vec_cnt++; if (Done !== 1'b1 || Busy !== 1'b0) begin
      err_cnt++; $display("FAIL basic_done got d=%0d b=%0d want d=1 b=0", Done, Busy); end
    step();
    vec_cnt++; if (Done !== 1'b0) begin
      err_cnt++; $display("FAIL basic_done_pulse got %0d want 0", Done); end
    $display("test_basic: 3-beat dump 1..3 done");
  endtask

  task automatic test_full;
    int nb, nd, nh;
    bit tmo;
    logic [31:0] exp;
    int bad;
    rf_clear();
    rf_write(5'd28, 32'h1800);
    rf_write(5'd29, 32'h2ffc);
    collect(5'd0, 5'd31, 1'b0, 200, nb, nd, nh, tmo);
    vec_cnt++; if (nb != 32 || nd != 1 || tmo) begin
      err_cnt++; $display("FAIL full_count got beats=%0d dones=%0d tmo=%0d want 32 1 0", nb, nd, tmo); end
    bad = 0;
    for (int i = 0; i < 32 && i < nb; i++) begin
      exp = (i == 28) ? 32'h1800 : (i == 29) ? 32'h2ffc : 32'd0;
      vec_cnt++; if (got_idx[i] !== 5'(i) || got_data[i] !== exp) begin
        err_cnt++; bad++;
        $display("FAIL full_beat%0d got idx=%0d data=%h want idx=%0d data=%h", i, got_idx[i], got_data[i], i, exp);
      end
    end
    $display("test_full: %0d beats, %0d bad", nb, bad);
  endtask

  task automatic test_empty;
    Start = 1'b1; FirstIdx = 5'd5; LastIdx = 5'd2; OutReady = 1'b1;
    step();
    Start = 1'b0;
    vec_cnt++; if (OutValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      err_cnt++; $display("FAIL empty_first got v=%0d b=%0d d=%0d want 0 0 0", OutValid, Busy, Done); end
    step();
    vec_cnt++; if (Done !== 1'b1 || OutValid !== 1'b0) begin
      err_cnt++; $display("FAIL empty_done got d=%0d v=%0d want d=1 v=0", Done, OutValid); end
    step();
    vec_cnt++; if (Done !== 1'b0 || OutValid !== 1'b0) begin
      err_cnt++; $display("FAIL empty_after got d=%0d v=%0d want 0 0", Done, OutValid); end
    $display("test_empty: range 5..2 done");
  endtask

  task automatic test_stall;
    int nb, nd, nh;
    bit tmo;
    logic [31:0] exp;
    for (int i = 1; i < 8; i++) rf_write(5'(i), 32'h100 + 32'(i));
    collect(5'd0, 5'd7, 1'b1, 200, nb, nd, nh, tmo);
    vec_cnt++; if (nb != 8 || nd != 1 || tmo) begin
      err_cnt++; $display("FAIL stall_count got beats=%0d dones=%0d tmo=%0d want 8 1 0", nb, nd, tmo); end
    vec_cnt++; if (nh != 0) begin
      err_cnt++; $display("FAIL stall_hold got %0d unstable cycles want 0", nh); end
    for (int i = 0; i < 8 && i < nb; i++) begin
      exp = (i == 0) ? 32'd0 : 32'h100 + 32'(i);
      vec_cnt++; if (got_idx[i] !== 5'(i) || got_data[i] !== exp) begin
        err_cnt++; $display("FAIL stall_beat%0d got idx=%0d data=%h want idx=%0d data=%h", i, got_idx[i], got_data[i], i, exp);
      end
    end
    $display("test_stall: %0d beats with ready pattern 1,0,0", nb);
  endtask

  task automatic test_coherency;
    int nb, nd, nh;
    bit tmo, seen;
    rf_write(5'd4, 32'h44);
    Start = 1'b1; FirstIdx = 5'd3; LastIdx = 5'd5; OutReady = 1'b1;
    step();
    Start = 1'b0;
    step();
    vec_cnt++; if (OutIdx !== 5'd3) begin
      err_cnt++; $display("FAIL coh_idx3 got %0d want 3", OutIdx); end
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hDEAD;
    step();
    wr_en = 1'b0;
    vec_cnt++; if (OutValid !== 1'b1 || OutIdx !== 5'd4 || OutData !== 32'h44) begin
      err_cnt++; $display("FAIL coh_old got v=%0d idx=%0d data=%h want v=1 idx=4 data=44", OutValid, OutIdx, OutData); end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (Done) seen = 1'b1;
    end
    vec_cnt++; if (!seen) begin
      err_cnt++; $display("FAIL coh_done got no Done pulse want one"); end
    step();
    collect(5'd4, 5'd4, 1'b0, 50, nb, nd, nh, tmo);
    vec_cnt++; if (nb != 1 || got_data[0] !== 32'hDEAD || got_idx[0] !== 5'd4) begin
      err_cnt++; $display("FAIL coh_new got beats=%0d idx=%0d data=%h want 1 4 dead", nb, got_idx[0], got_data[0]); end
    $display("test_coherency: old=%h then new via re-dump", 32'h44);
  endtask

  task automatic test_abort;
    int bad;
    Start = 1'b1; FirstIdx = 5'd0; LastIdx = 5'd9; OutReady = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
    vec_cnt++; if (OutValid !== 1'b1 || OutIdx !== 5'd1) begin
      err_cnt++; $display("FAIL abort_pre got v=%0d idx=%0d want v=1 idx=1", OutValid, OutIdx); end
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    vec_cnt++; if (OutValid !== 1'b0 || Busy !== 1'b0 || RdAddr !== 5'd0) begin
      err_cnt++; $display("FAIL abort_stop got v=%0d b=%0d a=%0d want 0 0 0", OutValid, Busy, RdAddr); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (Done !== 1'b0 || OutValid !== 1'b0) bad++;
      step();
    end
    vec_cnt++; if (bad != 0) begin
      err_cnt++; $display("FAIL abort_quiet got %0d cycles with Done/OutValid want 0", bad); end
    $display("test_abort: aborted after 2nd beat");
  endtask

  task automatic test_rst_mid;
    int nb, nd, nh;
    bit tmo;
    Start = 1'b1; FirstIdx = 5'd0; LastIdx = 5'd9; OutReady = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
    #2 Rst = 1'b1;
    #1;
    vec_cnt++; if (OutValid !== 1'b0 || OutIdx !== 5'd0 || OutData !== 32'd0 || Busy !== 1'b0 ||
                   Done !== 1'b0 || RdAddr !== 5'd0) begin
      err_cnt++; $display("FAIL rst_mid got v=%0d idx=%0d data=%h b=%0d d=%0d a=%0d want all 0",
                          OutValid, OutIdx, OutData, Busy, Done, RdAddr); end
    step();
    Rst = 1'b0;
    step();
    vec_cnt++; if (OutValid !== 1'b0 || Busy !== 1'b0) begin
      err_cnt++; $display("FAIL rst_resume got v=%0d b=%0d want 0 0", OutValid, Busy); end
    collect(5'd1, 5'd3, 1'b0, 50, nb, nd, nh, tmo);
    vec_cnt++; if (nb != 3 || nd != 1 || tmo) begin
      err_cnt++; $display("FAIL rst_redump_count got beats=%0d dones=%0d tmo=%0d want 3 1 0", nb, nd, tmo); end
    for (int i = 0; i < 3 && i < nb; i++) begin
      vec_cnt++; if (got_idx[i] !== 5'(i + 1) || got_data[i] !== 32'h101 + 32'(i)) begin
        err_cnt++; $display("FAIL rst_redump%0d got idx=%0d data=%h want idx=%0d data=%h",
                            i, got_idx[i], got_data[i], i + 1, 32'h101 + 32'(i)); end
    end
    $display("test_rst_mid: reset mid-dump then re-dump 1..3");
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; FirstIdx = '0; LastIdx = '0; Abort = 1'b0; OutReady = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step();
    step();
    test_reset();
    Rst = 1'b0;
    step();
    test_basic();
    test_full();
    test_empty();
    test_stall();
    test_coherency();
    test_abort();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
